// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - instruction class codes and MIPS opcode constants
// Purpose: shared by the encoder and the control unit.
// Contents: mnem_e (MN_* class codes, 5 bits), OP_* 6-bit opcodes, BGEZ rt selector.
package instr_pkg;

  typedef enum logic [4:0] {
    MN_R       = 5'd0,
    MN_BITSWAP = 5'd1,
    MN_LW      = 5'd2,
    MN_SW      = 5'd3,
    MN_ADDI    = 5'd4,
    MN_ADDIU   = 5'd5,
    MN_ANDI    = 5'd6,
    MN_ORI     = 5'd7,
    MN_XORI    = 5'd8,
    MN_SLTI    = 5'd9,
    MN_SLTIU   = 5'd10,
    MN_BEQ     = 5'd11,
    MN_BNE     = 5'd12,
    MN_LUI     = 5'd13,
    MN_B       = 5'd14,
    MN_BGEZ    = 5'd15,
    MN_J       = 5'd16
  } mnem_e;

  localparam logic [5:0] OP_R       = 6'b000000;
  localparam logic [5:0] OP_BITSWAP = 6'b011111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_B       = 6'b000011;
  localparam logic [5:0] OP_BGEZ    = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;

  // REGIMM rt selector that turns opcode 000001 into BGEZ.
  localparam logic [4:0] RT_BGEZ = 5'b00001;

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational instruction field packer
// Purpose: pack mnemonic class plus fields into a 32-bit MIPS word.
// Ports: mnem_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i in;
//        word_o (packed word), illegal_o (mnem_i is not a known class) out.
module instr_pack
  import instr_pkg::*;
(
  input  logic [4:0]  mnem_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (mnem_i)
      MN_R:       word_o = {OP_R, rs_i, rt_i, rd_i, shamt_i, funct_i};
      MN_BITSWAP: word_o = {OP_BITSWAP, rs_i, rt_i, rd_i, shamt_i, funct_i};
      MN_LW:      word_o = {OP_LW, rs_i, rt_i, imm_i};
      MN_SW:      word_o = {OP_SW, rs_i, rt_i, imm_i};
      MN_ADDI:    word_o = {OP_ADDI, rs_i, rt_i, imm_i};
      MN_ADDIU:   word_o = {OP_ADDIU, rs_i, rt_i, imm_i};
      MN_ANDI:    word_o = {OP_ANDI, rs_i, rt_i, imm_i};
      MN_ORI:     word_o = {OP_ORI, rs_i, rt_i, imm_i};
      MN_XORI:    word_o = {OP_XORI, rs_i, rt_i, imm_i};
      MN_SLTI:    word_o = {OP_SLTI, rs_i, rt_i, imm_i};
      MN_SLTIU:   word_o = {OP_SLTIU, rs_i, rt_i, imm_i};
      MN_BEQ:     word_o = {OP_BEQ, rs_i, rt_i, imm_i};
      MN_BNE:     word_o = {OP_BNE, rs_i, rt_i, imm_i};
      MN_LUI:     word_o = {OP_LUI, 5'b0, rt_i, imm_i};
      MN_B:       word_o = {OP_B, 10'b0, imm_i};
      MN_BGEZ:    word_o = {OP_BGEZ, rs_i, RT_BGEZ, imm_i};
      MN_J:       word_o = {OP_J, target_i};
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - instruction encoder writing packed words to instruction memory
// Purpose: accept instruction descriptions, pack them, write one word per request.
// Ports: clk, rst (sync, active-high); in_valid/in_ready request handshake;
//        mnem, rs, rt, rd, shamt, funct, imm, target, last request fields;
//        restart (DONE -> IDLE); mem_we/mem_addr/mem_wdata write port;
//        done, overflow, err_illegal status; count words written.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              last,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              overflow,
  output logic              err_illegal,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic [31:0]       packed_word;
  logic              packed_illegal;
  logic              accept;

  instr_pack u_pack (
    .mnem_i   (mnem),
    .rs_i     (rs),
    .rt_i     (rt),
    .rd_i     (rd),
    .shamt_i  (shamt),
    .funct_i  (funct),
    .imm_i    (imm),
    .target_i (target),
    .word_o   (packed_word),
    .illegal_o(packed_illegal)
  );

  // Gated by rst so nothing is seen as accepted in the reset cycle.
  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          last_d = last;
          if (packed_illegal) begin
            err_d = 1'b1;
            if (last) state_d = ST_DONE;
          end else begin
            wdata_d = packed_word;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
        // The top word ends the program: the address is held, never wrapped.
        if (addr_q == {ADDR_W{1'b1}}) begin
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d = last_q ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: begin
        if (restart) begin
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign mem_we      = (state_q == ST_WRITE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign done        = (state_q == ST_DONE);
  assign overflow    = ovf_q;
  assign err_illegal = err_q;
  assign count       = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
  import instr_pkg::*;

  logic clk = 1'b0;
  logic rst, in_valid, last, restart;
  logic [4:0] mnem, rs, rt, rd, shamt;
  logic [5:0] funct;
  logic [15:0] imm;
  logic [25:0] target;

  logic in_ready, mem_we, done, overflow, err_illegal;
  logic [7:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0] count;

  logic rdy2, we2, done2, ovf2, err2;
  logic [1:0] addr2;
  logic [31:0] wd2;
  logic [2:0] cnt2;

  int checks = 0;
  int failures = 0;
  int exp_addr, exp_count;
  bit exp_err;
  logic [31:0] last_wdata;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target), .last(last), .restart(restart),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .overflow(overflow), .err_illegal(err_illegal), .count(count)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target), .last(last), .restart(restart),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wd2),
    .done(done2), .overflow(ovf2), .err_illegal(err2), .count(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoding from opcode numbers and field bit positions.
  function automatic logic [31:0] ref_word(input logic [4:0] m, input logic [4:0] s, t, d, sh,
                                           input logic [5:0] fn, input logic [15:0] im,
                                           input logic [25:0] tg, output bit legal);
    logic [31:0] rw, iw, w;
    rw = (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | (32'(sh) << 6) | 32'(fn);
    iw = (32'(s) << 21) | (32'(t) << 16) | 32'(im);
    legal = 1'b1;
    w = 32'd0;
    case (m)
      MN_R:       w = rw;
      MN_BITSWAP: w = (32'd31 << 26) | rw;
      MN_LW:      w = (32'd35 << 26) | iw;
      MN_SW:      w = (32'd43 << 26) | iw;
      MN_ADDI:    w = (32'd8 << 26) | iw;
      MN_ADDIU:   w = (32'd9 << 26) | iw;
      MN_ANDI:    w = (32'd12 << 26) | iw;
      MN_ORI:     w = (32'd13 << 26) | iw;
      MN_XORI:    w = (32'd14 << 26) | iw;
      MN_SLTI:    w = (32'd10 << 26) | iw;
      MN_SLTIU:   w = (32'd11 << 26) | iw;
      MN_BEQ:     w = (32'd4 << 26) | iw;
      MN_BNE:     w = (32'd5 << 26) | iw;
      MN_LUI:     w = (32'd15 << 26) | (32'(t) << 16) | 32'(im);
      MN_B:       w = (32'd3 << 26) | 32'(im);
      MN_BGEZ:    w = (32'd1 << 26) | (32'(s) << 21) | (32'd1 << 16) | 32'(im);
      MN_J:       w = (32'd2 << 26) | 32'(tg);
      default:    legal = 1'b0;
    endcase
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_addr = 0;
    exp_count = 0;
    exp_err = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    exp_addr = 0;
    exp_count = 0;
    exp_err = 1'b0;
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_rdy", 32'(in_ready), 32'd1);
  endtask

  task automatic send(input logic [4:0] m, s, t, d, sh, input logic [5:0] fn,
                      input logic [15:0] im, input logic [25:0] tg, input bit lst,
                      input string tag);
    bit legal;
    logic [31:0] exp_w;
    exp_w = ref_word(m, s, t, d, sh, fn, im, tg, legal);
    @(negedge clk);
    mnem = m; rs = s; rt = t; rd = d; shamt = sh; funct = fn;
    imm = im; target = tg; last = lst; in_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last = 1'b0;
    if (legal) begin
      chk({tag, "_we"}, 32'(mem_we), 32'd1);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
      chk({tag, "_wdata"}, mem_wdata, exp_w);
      last_wdata = mem_wdata;
      @(posedge clk);
      #1;
      exp_addr++;
      exp_count++;
      chk({tag, "_we_off"}, 32'(mem_we), 32'd0);
    end else begin
      exp_err = 1'b1;
      chk({tag, "_we_ill"}, 32'(mem_we), 32'd0);
    end
    chk({tag, "_count"}, 32'(count), 32'(exp_count));
    chk({tag, "_err"}, 32'(err_illegal), 32'(exp_err));
    chk({tag, "_done"}, 32'(done), 32'(lst));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; last = 1'b0; restart = 1'b0;
    mnem = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", 32'(in_ready), 32'd0);
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_flags", {29'd0, done, overflow, err_illegal}, 32'd0);
    rst = 1'b0;
    exp_addr = 0; exp_count = 0; exp_err = 1'b0;

    send(MN_ADDI, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0, "addi");
    chk("addi_const", last_wdata, 32'h20080005);

    do_reset();
    send(MN_R, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0, "rtype");
    chk("rtype_const", last_wdata, 32'h01095020);
    send(MN_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b0, "jump");
    chk("jump_const", last_wdata, 32'h08000010);

    do_reset();
    send(MN_LUI, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0, "lui");
    chk("lui_const", last_wdata, 32'h3C011234);
    send(MN_BGEZ, 5'd8, 5'd0, 5'd0, 5'd0, 6'd0, 16'hFFFE, 26'd0, 1'b1, "bgez");
    chk("bgez_const", last_wdata, 32'h0501FFFE);
    chk("bgez_rdy", 32'(in_ready), 32'd0);
    do_restart();
    chk("restart_addr", 32'(mem_addr), 32'd0);

    send(5'd25, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'd6, 26'd7, 1'b0, "illegal");
    send(MN_ADDIU, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h8001, 26'd0, 1'b0, "addiu");
    chk("addiu_err", 32'(err_illegal), 32'd1);
    chk("addiu_count", 32'(count), 32'd1);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [4:0] m;
      m = ($urandom_range(0, 9) == 0) ? 5'(31 - $urandom_range(0, 14)) : 5'($urandom_range(0, 16));
      send(m, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
           16'($urandom), 26'($urandom), 1'b0, "rand");
    end
    send(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1, "ill_last");
    chk("ill_last_rdy", 32'(in_ready), 32'd0);
    do_restart();
    chk("ill_restart_err", 32'(err_illegal), 32'd0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mnem = MN_ADDI; rs = 5'd1; rt = 5'd2; imm = 16'(i); last = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("ovf_we", 32'(we2), 32'd1);
      chk("ovf_addr", 32'(addr2), 32'(i));
      chk("ovf_wdata", wd2, 32'h20220000 + 32'(i));
      @(posedge clk);
      #1;
    end
    chk("ovf_flag", 32'(ovf2), 32'd1);
    chk("ovf_done", 32'(done2), 32'd1);
    chk("ovf_count", 32'(cnt2), 32'd4);
    chk("ovf_hold", 32'(addr2), 32'd3);
    @(negedge clk);
    in_valid = 1'b1;
    chk("ovf5_rdy", 32'(rdy2), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ovf5_we", 32'(we2), 32'd0);
    @(posedge clk);
    #1;
    chk("ovf5_count", 32'(cnt2), 32'd4);
    @(negedge clk);
    restart = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    in_valid = 1'b0;
    chk("rst2_we", 32'(we2), 32'd0);
    chk("rst2_addr", 32'(addr2), 32'd0);
    chk("rst2_count", 32'(cnt2), 32'd0);
    chk("rst2_flags", {29'd0, done2, ovf2, err2}, 32'd0);
    chk("rst2_rdy", 32'(rdy2), 32'd1);
    @(posedge clk);
    #1;
    chk("rst2_no_accept", 32'(we2), 32'd0);

    do_reset();
    @(negedge clk);
    mnem = MN_ORI; rs = 5'd7; rt = 5'd9; imm = 16'hBEEF; last = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    chk("abort_we_before", 32'(mem_we), 32'd1);
    chk("abort_rdy", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_wdata", mem_wdata, 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_flags", {29'd0, done, overflow, err_illegal}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_after_we", 32'(mem_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 8, instruction-memory word-address width.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  request carries a valid instruction description.
REQ-005 Port: in_ready  output  1  encoder can accept a request this cycle.
REQ-006 Port: mnem  input  5  instruction class code (MN_*), defined in instr_pkg.
REQ-007 Port: rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-008 Port: funct  input  6  R-type function field.
REQ-009 Port: imm  input  16  I-type immediate.
REQ-010 Port: target  input  26  J-type target.
REQ-011 Port: last  input  1  the accepted request is the final instruction of the program.
REQ-012 Port: restart  input  1  single-cycle pulse; returns the block from DONE to IDLE.
REQ-013 Port: mem_we, mem_addr, mem_wdata  output  1/ADDR_W/32  instruction-memory write port.
REQ-014 Port: done, overflow, err_illegal  output  1 each  status flags.
REQ-015 Port: count  output  ADDR_W+1  number of words written since reset or restart.

Function
REQ-016 The FSM SHALL have the states IDLE, WRITE and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 A request is accepted when in_valid and in_ready are both high; the word SHALL be packed and registered in that cycle.
REQ-018 On acceptance of a legal mnem: IDLE->WRITE; in WRITE, mem_we=1 for exactly one cycle, with the word at mem_addr; then mem_addr++ and count++.
REQ-019 Latency SHALL be exactly 1 cycle (acceptance edge to the mem_we cycle); throughput SHALL be one instruction per 2 cycles.
REQ-020 Encoding for R (000000) and BITSWAP (011111) SHALL be {op,rs,rt,rd,shamt,funct}.
REQ-021 Encoding for LW, SW, ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, BEQ and BNE SHALL be {op,rs,rt,imm}, using the standard MIPS opcodes 100011/101011/001000/001001/001100/001101/001110/001010/001011/000100/000101.
REQ-022 LUI SHALL encode as {001111,5'b0,rt,imm}, and B as {000011,10'b0,imm}.
REQ-023 BGEZ SHALL encode as {000001,rs,5'b00001,imm}, and J as {000010,target}.
REQ-024 For an illegal mnem: the request is accepted, no write occurs, address and count are unchanged, err_illegal is set (sticky until reset or restart), and the FSM stays in IDLE; with last=1, it goes to DONE.
REQ-025 After WRITE with last=1, the FSM SHALL go to DONE and set done=1.
REQ-026 A write at mem_addr = 2^ADDR_W-1 SHALL set overflow and go to DONE regardless of last; mem_addr SHALL never wrap.
REQ-027 In DONE, in_valid SHALL be ignored; restart SHALL clear mem_addr, count, done, overflow and err_illegal, and go to IDLE next cycle.
REQ-028 restart in IDLE or WRITE SHALL be ignored.
REQ-029 If restart and in_valid coincide in DONE, the request SHALL not be accepted (in_ready is 0).

Reset
REQ-030 rst SHALL force IDLE, and mem_we=0, mem_addr=0, mem_wdata=0, count=0, done=0, overflow=0 and err_illegal=0 on the next edge.
REQ-031 rst SHALL take priority over all inputs; rst asserted during WRITE SHALL abort the write, so mem_we=0 in the following cycle.
REQ-032 in_ready SHALL be 0 while rst is high.

Structure
REQ-033 The MN_* codes and OP_* opcode constants SHALL live in the shared package instr_pkg, also used by the control unit.
REQ-034 The field packing SHALL be a combinational sub-module instr_pack (mnem plus fields in; word and illegal out); the FSM and counters stay in instr_encoder.

Verification
REQ-035 ADDI, rs=0, rt=8, imm=5, last=0: after acceptance at cycle T, cycle T+1 shall show mem_we=1, mem_addr=0, mem_wdata=0x20080005, then count=1.
REQ-036 R, rs=8, rt=9, rd=10, shamt=0, funct=0x20, then J with target=0x10: the bench shall check 0x01095020 at addr 0 and 0x08000010 at addr 1.
REQ-037 LUI rt=1 imm=0x1234 shall give 0x3C011234; BGEZ rs=8 imm=0xFFFE with last=1 shall give 0x0501FFFE, then done=1 and in_ready=0.
REQ-038 An illegal mnem followed by ADDIU: err_illegal=1, the ADDIU shall be written at addr 0, and count=1.
REQ-039 ADDR_W=2 with 4 writes, last=0: the 4th write is at addr 3, overflow=1, done=1; a 5th in_valid shall be ignored; restart shall give addr 0 and flags cleared.
REQ-040 rst asserted in the WRITE cycle shall give no mem_we afterwards, and all outputs 0.
